// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with valid/ready handshakes on both sides.
// Words are loaded whole, then emitted MSB- or LSB-first one bit per transfer.
module piso_serializer #(
   parameter int N  = 8,
   parameter int CW = $clog2(N)
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] din,
   input  logic         lsb_first,
   input  logic         sin,
   input  logic         sout_ready,
   output logic         sout,
   output logic         sout_valid,
   output logic         sout_last,
   output logic         busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  shreg, shreg_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          order, order_nxt;

   logic shifting;
   logic on_last;
   logic xfer;
   logic accept;

   always_comb begin
      shifting   = (state == SHIFT);
      on_last    = shifting && (cnt == '0);
      xfer       = shifting && sout_ready;
      // A new word may land on the same edge that retires the final bit.
      load_ready = !clear && (!shifting || (on_last && sout_ready));
      accept     = load_valid && load_ready;

      sout_valid = shifting;
      busy       = shifting;
      sout_last  = on_last;
      sout       = shifting ? (order ? shreg[0] : shreg[N-1]) : 1'b0;
   end

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      order_nxt = order;

      if (accept) begin
         state_nxt = SHIFT;
         shreg_nxt = din;
         cnt_nxt   = CW'(N - 1);
         order_nxt = lsb_first;
      end else if (xfer) begin
         shreg_nxt = order ? {sin, shreg[N-1:1]} : {shreg[N-2:0], sin};
         cnt_nxt   = cnt - CW'(1);
         if (on_last) begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (clear) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         order <= 1'b0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
         order <= order_nxt;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: a queue-of-bits model predicts every output each cycle,
// plus directed words whose serial streams are compared against literals.
module tb_piso_serializer;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         clear = 1'b1;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [N-1:0] din = '0;
   logic         lsb_first = 1'b0;
   logic         sin = 1'b0;
   logic         sout_ready = 1'b0;
   logic         sout;
   logic         sout_valid;
   logic         sout_last;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   bit mq[$];
   bit cmp_en = 1'b0;

   logic [63:0] rec;
   int rec_n, valid_cnt, last_pos, first_vc, last_vc;
   int cyc = 0;

   piso_serializer #(.N(N)) dut (
      .clk        (clk),
      .clear      (clear),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .din        (din),
      .lsb_first  (lsb_first),
      .sin        (sin),
      .sout_ready (sout_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the queue holds the bits of the current word still to be emitted.
   always @(posedge clk) begin : model
      bit rdy;
      rdy = (mq.size() == 0) || (mq.size() == 1 && sout_ready);
      if (clear) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && sout_ready) mq.delete(0);
         if (load_valid && rdy) begin
            mq.delete();
            for (int i = 0; i < N; i++) mq.push_back(lsb_first ? din[i] : din[N-1-i]);
         end
      end
   end

   always @(negedge clk) begin : compare
      bit   e_valid, e_last, e_ready;
      logic e_sout;
      cyc++;
      if (sout_valid && sout_ready) begin
         rec = {rec[62:0], sout};
         rec_n++;
      end
      if (sout_valid) begin
         valid_cnt++;
         if (first_vc < 0) first_vc = cyc;
         last_vc = cyc;
      end
      if (sout_last) last_pos = valid_cnt;
      if (cmp_en) begin
         e_valid = (mq.size() != 0);
         e_sout  = e_valid ? mq[0] : 1'b0;
         e_last  = (mq.size() == 1);
         e_ready = !clear && ((mq.size() == 0) || (mq.size() == 1 && sout_ready));
         check("model_sout_valid", 64'(sout_valid), 64'(e_valid));
         check("model_busy",       64'(busy),       64'(e_valid));
         check("model_sout",       64'(sout),       64'(e_sout));
         check("model_sout_last",  64'(sout_last),  64'(e_last));
         check("model_load_ready", 64'(load_ready), 64'(e_ready));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_rec();
      rec = '0; rec_n = 0; valid_cnt = 0; last_pos = 0; first_vc = -1; last_vc = -1;
   endtask

   task automatic send_word(input logic [N-1:0] w, input logic lsb);
      int n = 0;
      din = w; lsb_first = lsb; load_valid = 1'b1;
      #1;
      while (!load_ready && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) check("accept_timeout", 64'(n), 64'(0));
      tick();
      load_valid = 1'b0;
      din = N'($urandom);
      lsb_first = 1'($urandom);
   endtask

   initial begin
      clr_rec();
      tick(); tick();
      cmp_en = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      check("rst_sout_valid", 64'(sout_valid), 64'(0));
      check("rst_busy",       64'(busy),       64'(0));
      check("rst_sout",       64'(sout),       64'(0));
      check("rst_load_ready", 64'(load_ready), 64'(1));

      // A5 MSB first
      sout_ready = 1'b1; sin = 1'($urandom);
      clr_rec();
      send_word(8'hA5, 1'b0);
      repeat (10) tick();
      check("a5_msb_bits",  rec[7:0], 64'hA5);
      check("a5_msb_count", 64'(rec_n), 64'(8));
      check("a5_last_pos",  64'(last_pos), 64'(8));
      check("a5_idle",      64'(busy), 64'(0));

      // A5 LSB first, then 01 LSB first
      clr_rec();
      send_word(8'hA5, 1'b1);
      repeat (10) tick();
      check("a5_lsb_bits", rec[7:0], 64'hA5);
      clr_rec();
      send_word(8'h01, 1'b1);
      repeat (10) tick();
      check("01_lsb_bits",  rec[7:0], 64'h80);
      check("01_lsb_count", 64'(rec_n), 64'(8));

      // Back-to-back F0 then 0F with load_valid held high
      clr_rec();
      begin
         int n = 0;
         din = 8'hF0; lsb_first = 1'b0; load_valid = 1'b1;
         #1;
         check("b2b_first_ready", 64'(load_ready), 64'(1));
         tick();
         din = 8'h0F;
         #1;
         while (!load_ready && n < 64) begin
            tick();
            n++;
         end
         check("b2b_wait_cycles", 64'(n), 64'(7));
         tick();
         load_valid = 1'b0;
      end
      repeat (12) tick();
      check("b2b_bits",       rec[15:0], 64'hF00F);
      check("b2b_valid_cnt",  64'(valid_cnt), 64'(16));
      check("b2b_contiguous", 64'(last_vc - first_vc + 1), 64'(16));

      // C3 with a 3-cycle stall after bit 2
      clr_rec();
      send_word(8'hC3, 1'b0);
      tick(); tick();
      sout_ready = 1'b0;
      repeat (3) tick();
      sout_ready = 1'b1;
      repeat (10) tick();
      check("stall_bits",      rec[7:0], 64'hC3);
      check("stall_count",     64'(rec_n), 64'(8));
      check("stall_valid_cnt", 64'(valid_cnt), 64'(11));

      // clear on bit 4 aborts, then 81 serialises cleanly
      clr_rec();
      send_word(8'h5A, 1'b0);
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      check("abort_sout_valid", 64'(sout_valid), 64'(0));
      check("abort_busy",       64'(busy),       64'(0));
      check("abort_load_ready", 64'(load_ready), 64'(1));
      repeat (4) tick();
      check("abort_bits_emitted", 64'(rec_n), 64'(4));
      check("abort_bits",         rec[3:0], 64'h5);
      clr_rec();
      send_word(8'h81, 1'b0);
      repeat (10) tick();
      check("after_abort_bits", rec[7:0], 64'h81);

      // din / lsb_first churn during SHIFT, sin held 1
      clr_rec();
      sin = 1'b1;
      send_word(8'h3C, 1'b0);
      for (int i = 0; i < 10; i++) begin
         din = N'($urandom);
         lsb_first = ~lsb_first;
         tick();
      end
      check("churn_bits",  rec[7:0], 64'h3C);
      check("churn_count", 64'(rec_n), 64'(8));

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         load_valid = ($urandom_range(0, 3) != 0);
         din        = N'($urandom);
         lsb_first  = 1'($urandom);
         sin        = 1'($urandom);
         sout_ready = ($urandom_range(0, 3) != 0);
         clear      = ($urandom_range(0, 99) == 0);
         tick();
      end
      clear = 1'b0; load_valid = 1'b0; sout_ready = 1'b1;
      repeat (12) tick();
      check("drain_idle", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
